fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Read-side consumer for the 8x8 synchronous FIFO. It pops one byte whenever the FIFO is non-empty and the serializer is idle, then sends the byte on a UART line. Frame format is start bit, 8 data bits LSB first, optional even parity, and 1 or 2 stop bits. It sits between the FIFO's q/empty/rd interface and the board TX pin.

Parameters:
WIDTH, 8, data width of fifo_q; the frame always carries 8 data bits and WIDTH must be 8.
BAUD_DIV, 434, clocks per bit (50 MHz / 115200); legal range 2..65535.
PARITY_EN, 0, 1 appends an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
fifo_empty  input  1  FIFO empty flag.
fifo_q  input  WIDTH  FIFO read data; valid the cycle after fifo_rd is high.
fifo_rd  output  1  FIFO read strobe; registered, one-cycle pulse per byte.
tx  output  1  serial line; idles high.
busy  output  1  high from the RD state through the last stop bit.
tx_done  output  1  one-cycle pulse on the clock after the last stop bit completes.

Behaviour:
- Reset values: state=IDLE, fifo_rd=0, tx=1, busy=0, tx_done=0, baud counter=0, bit counter=0, shift register=0.
- Reset has priority over every other input and takes effect on the next rising edge, including mid-frame.
- States: IDLE, RD, LOAD, START, DATA, PAR, STOP.
- IDLE: if fifo_empty=0 at the edge, go to RD with fifo_rd=1. Otherwise stay, with tx=1 and fifo_rd=0.
- RD: fifo_rd is 1 for exactly this one cycle. Go to LOAD unconditionally.
- LOAD: capture fifo_q into the shift register. Go to START with tx=0 and baud counter=0. The parity bit is computed here as the XOR of the 8 data bits.
- Bit timing: the baud counter runs 0..BAUD_DIV-1. Each bit holds tx for exactly BAUD_DIV clocks. Counter wrap advances to the next bit or state.
- START: tx=0 for BAUD_DIV clocks, then go to DATA with bit counter=0.
- DATA: tx = shift register bit 0, shifting right on each wrap. After bit 7 go to PAR if PARITY_EN=1, else to STOP.
- PAR: tx = parity bit for BAUD_DIV clocks, then go to STOP.
- STOP: tx=1 for STOP_BITS*BAUD_DIV clocks. On completion tx_done pulses on the next cycle.
  - If fifo_empty=0 at the final edge, go directly to RD (back-to-back).
  - Otherwise go to IDLE.
- Latency: tx falls 3 clocks after the IDLE edge that sees fifo_empty=0 (edges: IDLE->RD, RD->LOAD, LOAD->START).
- Frame length is (10 + PARITY_EN + STOP_BITS - 1) * BAUD_DIV clocks.
- Back-to-back inter-frame gap is exactly 2 clocks of tx=1 (the RD and LOAD states).
- fifo_rd is never asserted while fifo_empty=1 at the deciding edge. It is never asserted twice per frame.
- fifo_empty is ignored outside IDLE and the STOP exit edge. The FIFO filling or draining mid-frame does not disturb the frame.
- fifo_q is sampled only in LOAD; changes at any other time are ignored.
- busy = (state != IDLE). tx is registered (glitch-free).
- Reset mid-frame: the next edge gives tx=1, IDLE, and no tx_done. The aborted byte is lost; the FIFO is not re-read for it.

Test Plan:
1. BAUD_DIV=4, PARITY_EN=0, STOP_BITS=1; FIFO holds 0xab.
   - fifo_rd pulses 1 clock.
   - tx per 4-clock bit reads 0,1,1,0,1,0,1,0,1,1 (start, data 1,1,0,1,0,1,0,1, stop).
   - tx_done pulses once after 40 clocks; busy then falls.
2. PARITY_EN=1, STOP_BITS=2; byte 0xab (five ones).
   - Parity bit is 1, followed by 8 clocks of stop.
   - Frame is 48 clocks; a second byte 0x01 gives parity bit 1, 0x03 gives parity bit 0.
3. FIFO holds 0x12 then 0x34, BAUD_DIV=4.
   - Two frames with exactly 2 clocks of tx=1 between the stop end and the next start.
   - fifo_rd pulses exactly twice; data bits decode to 0x12 then 0x34.
4. fifo_empty held 1 for 100 clocks after reset.
   - fifo_rd=0, tx=1, busy=0, tx_done=0 throughout.
5. Assert rst for 1 clock during data bit 3 of 0x56.
   - Next edge: tx=1, busy=0, fifo_rd=0, no tx_done.
   - With fifo_empty=0 after reset release, a new full frame starts with fifo_rd on the first IDLE edge.
6. fifo_empty toggles and fifo_q changes every clock during a frame of 0xcd.
   - Transmitted bits still decode to 0xcd.
   - No fifo_rd occurs until the STOP exit edge.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO, one byte per frame.
// Frame: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BAUD_DIV  = 434,
    parameter int unsigned PARITY_EN = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int unsigned   CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_PAR   = 3'd5;
    localparam logic [2:0] ST_STOP  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic          fifo_rd_q, fifo_rd_d;
    logic          tx_q, tx_d;
    logic          tx_done_q, tx_done_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        fifo_rd_d = 1'b0;
        tx_d      = tx_q;
        tx_done_d = 1'b0;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d   = ST_RD;
                    fifo_rd_d = 1'b1;
                end
            end

            ST_RD: begin
                tx_d    = 1'b1;
                state_d = ST_LOAD;
            end

            // fifo_q is valid here, one cycle after the read strobe.
            ST_LOAD: begin
                shift_d = fifo_q[7:0];
                par_d   = ^fifo_q[7:0];
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = ST_START;
            end

            ST_START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            ST_DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = ST_PAR;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            ST_PAR: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            // bit_q counts stop bits; the exit edge also decides a back-to-back read.
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d     = 3'd0;
                        tx_done_d = 1'b1;
                        if (!fifo_empty) begin
                            state_d   = ST_RD;
                            fifo_rd_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fifo_rd_q <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fifo_rd_q <= fifo_rd_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    assign fifo_rd = fifo_rd_q;
    assign tx      = tx_q;
    assign tx_done = tx_done_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
